// File: rtl/conv_output_streamer.sv
// rtl/conv_output_streamer.sv - frame capture and word-serial readout of the pooled conv output
//
// Purpose:
//   Captures the flat pooled-output bus of integrationConv on a start pulse and
//   replays it one DATA_WIDTH word per accepted valid/ready handshake. Each word
//   carries its channel/pixel position and an end-of-frame marker.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        single-cycle capture request
//   iConvOutput  flat frame, word k = [k*DATA_WIDTH +: DATA_WIDTH]
//   outData      current stream word
//   outValid     outData and side-band valid
//   outReady     downstream accept
//   outLast      final word of the frame
//   outChannel   channel index of the current word
//   outPixel     pixel index within the channel
//   busy         frame held / streaming
//   overrun      sticky, start seen while busy
//   frameCount   completed frames, wraps
module conv_output_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int MvgP3out   = 3,
  parameter int DepthC3    = 32,
  localparam int NUM_WORDS = MvgP3out * MvgP3out * DepthC3,
  localparam int PIX       = MvgP3out * MvgP3out,
  localparam int CH_W      = $clog2(DepthC3),
  localparam int PIX_W     = $clog2(PIX)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] iConvOutput,
  output logic [DATA_WIDTH-1:0]           outData,
  output logic                            outValid,
  input  logic                            outReady,
  output logic                            outLast,
  output logic [CH_W-1:0]                 outChannel,
  output logic [PIX_W-1:0]                outPixel,
  output logic                            busy,
  output logic                            overrun,
  output logic [7:0]                      frameCount
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state_q, state_d;
  logic [NUM_WORDS*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0]           data_q, data_d;
  logic                            valid_q, valid_d;
  logic                            last_q, last_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic [PIX_W-1:0]                pix_q, pix_d;
  logic                            busy_q, busy_d;
  logic                            ovr_q, ovr_d;
  logic [7:0]                      fc_q, fc_d;

  logic capture;
  logic xfer;
  logic last_xfer;

  assign capture   = (state_q == IDLE) && start;
  assign xfer      = valid_q && outReady;
  assign last_xfer = xfer && last_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ch_q    <= '0;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      fc_q    <= fc_d;
    end
  end

  // Frame contents carry no reset value; they are always overwritten on capture.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = STREAM;
      STREAM:  if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. The shadow is consumed as a shift register so
  // the next word is always at the bottom, avoiding a wide k-indexed mux.
  always_comb begin
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    ch_d     = ch_q;
    pix_d    = pix_q;
    busy_d   = busy_q;
    fc_d     = fc_q;
    ovr_d    = ovr_q | (start && (state_q == STREAM));

    if (capture) begin
      shadow_d = iConvOutput >> DATA_WIDTH;
      data_d   = iConvOutput[DATA_WIDTH-1:0];
      valid_d  = 1'b1;
      busy_d   = 1'b1;
      ch_d     = '0;
      pix_d    = '0;
      last_d   = (NUM_WORDS == 1);
    end else if (last_xfer) begin
      data_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      ch_d    = '0;
      pix_d   = '0;
      fc_d    = fc_q + 8'd1;
    end else if (xfer) begin
      shadow_d = shadow_q >> DATA_WIDTH;
      data_d   = shadow_q[DATA_WIDTH-1:0];
      if (pix_q == PIX_W'(PIX - 1)) begin
        pix_d = '0;
        ch_d  = ch_q + 1'b1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
      last_d = (ch_d == CH_W'(DepthC3 - 1)) && (pix_d == PIX_W'(PIX - 1));
    end
  end

  assign outData    = data_q;
  assign outValid   = valid_q;
  assign outLast    = last_q;
  assign outChannel = ch_q;
  assign outPixel   = pix_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
  assign frameCount = fc_q;

endmodule

// File: tb/tb_conv_output_streamer.sv
// tb/tb_conv_output_streamer.sv - self-checking bench for conv_output_streamer
module tb_conv_output_streamer;

  localparam int DW  = 16;
  localparam int NW  = 288;
  localparam int PIX = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             outReady = 1'b0;
  logic [NW*DW-1:0] iconv = '0;
  logic [DW-1:0]    outData;
  logic             outValid;
  logic             outLast;
  logic [4:0]       outChannel;
  logic [3:0]       outPixel;
  logic             busy;
  logic             overrun;
  logic [7:0]       frameCount;

  conv_output_streamer dut (
    .clk(clk), .reset(reset), .start(start), .iConvOutput(iconv),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .outChannel(outChannel), .outPixel(outPixel),
    .busy(busy), .overrun(overrun), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_fc   = 0;
  bit          exp_ovr  = 1'b0;
  logic [15:0] exp_w [NW];

  task automatic gen_frame(input bit ramp);
    for (int k = 0; k < NW; k++) begin
      exp_w[k] = ramp ? 16'(k) : 16'($urandom);
      iconv[k*DW +: DW] = exp_w[k];
    end
  endtask

  // Captures a frame, then streams it with outReady asserted rdy_pct percent
  // of cycles, checking every word against the captured frame.
  task automatic run_frame(input bit ramp, input int rdy_pct, input bit scramble,
                           input bit ovr_mid, input bit ovr_last, input int rst_at);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit sent_mid = 1'b0;
    gen_frame(ramp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) iconv = '1;
    while (idx < NW && cyc < 4000) begin
      n_checks++;
      if (outValid !== 1'b1) begin n_fail++; $display("FAIL valid idx=%0d: got %b want 1", idx, outValid); end
      n_checks++;
      if (outData !== exp_w[idx]) begin n_fail++; $display("FAIL data idx=%0d: got %h want %h", idx, outData, exp_w[idx]); end
      n_checks++;
      if (outChannel !== 5'(idx / PIX)) begin n_fail++; $display("FAIL channel idx=%0d: got %0d want %0d", idx, outChannel, idx / PIX); end
      n_checks++;
      if (outPixel !== 4'(idx % PIX)) begin n_fail++; $display("FAIL pixel idx=%0d: got %0d want %0d", idx, outPixel, idx % PIX); end
      n_checks++;
      if (outLast !== (idx == NW - 1)) begin n_fail++; $display("FAIL last idx=%0d: got %b want %b", idx, outLast, idx == NW - 1); end
      n_checks++;
      if (busy !== 1'b1 || overrun !== exp_ovr) begin n_fail++; $display("FAIL busy_ovr idx=%0d: got %b%b want 1%b", idx, busy, overrun, exp_ovr); end
      if (idx == rst_at) begin
        reset = 1'b0;
        outReady = 1'b0;
        #1;
        exp_fc = 0;
        exp_ovr = 1'b0;
        n_checks++;
        if ({outData, outValid, outLast, outChannel, outPixel, busy, overrun, frameCount} !== '0) begin
          n_fail++;
          $display("FAIL mid_reset_outputs: got data=%h v=%b l=%b ch=%0d px=%0d b=%b o=%b fc=%0d want all 0",
                   outData, outValid, outLast, outChannel, outPixel, busy, overrun, frameCount);
        end
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      outReady = rdy;
      if (ovr_mid && idx == 100 && !sent_mid) begin start = 1'b1; sent_mid = 1'b1; exp_ovr = 1'b1; end
      if (ovr_last && idx == NW - 1 && rdy) begin start = 1'b1; exp_ovr = 1'b1; end
      if (rdy) idx++;
      if (idx == NW) exp_fc++;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    outReady = 1'b0;
    n_checks++;
    if (idx != NW) begin n_fail++; $display("FAIL transfer_count: got %0d want %0d", idx, NW); end
    n_checks++;
    if ({outValid, busy, outLast} !== 3'b000) begin n_fail++; $display("FAIL post_frame_idle: got v,b,l=%b%b%b want 000", outValid, busy, outLast); end
    n_checks++;
    if (frameCount !== 8'(exp_fc)) begin n_fail++; $display("FAIL frame_count: got %0d want %0d", frameCount, exp_fc); end
    n_checks++;
    if (overrun !== exp_ovr) begin n_fail++; $display("FAIL overrun: got %b want %b", overrun, exp_ovr); end
  endtask

  task automatic test_reset;
    int seen = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({outData, outValid, outLast, outChannel, outPixel, busy, overrun, frameCount} !== '0) begin
      n_fail++; $display("FAIL reset_held: got nonzero outputs data=%h v=%b want all 0", outData, outValid);
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (outValid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL idle_valid: got %0d valid cycles want 0", seen); end
    n_checks++;
    if ({outData, outValid, outLast, outChannel, outPixel, busy, overrun, frameCount} !== '0) begin
      n_fail++; $display("FAIL idle_outputs: got data=%h b=%b o=%b fc=%0d want all 0", outData, busy, overrun, frameCount);
    end
  endtask

  task automatic test_full_frame;
    run_frame(1'b1, 100, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure;
    run_frame(1'b1, 50, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_capture_isolation;
    run_frame(1'b0, 70, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_overrun;
    run_frame(1'b0, 60, 1'b0, 1'b1, 1'b1, -1);
    run_frame(1'b0, 80, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    run_frame(1'b0, 100, 1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b0, 100, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_frame;
    run_frame(1'b0, 75, 1'b0, 1'b0, 1'b0, 150);
    run_frame(1'b1, 90, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_backpressure;
    test_capture_isolation;
    test_overrun;
    test_back_to_back;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
